// File: rtl/fini_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fini_pkg
// Purpose  : Shared types and helpers for the FINI fault-response stage:
//            state encoding, default codeword width, saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
package fini_pkg;

    // Codeword width produced by the FINI multiplier/detection stage
    localparam int c_FINI_WIDTH = 4;

    // Response-stage states; encoding is fixed so the decodes stay stable
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ALARM  = 2'd1,
        ST_LOCKED = 2'd2
    } fini_state_e;

    // Increment that sticks at the all-ones value of a counter WIDTH bits wide
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fini_alarm_timer.sv
`default_nettype none
// ============================================================================
// Module   : fini_alarm_timer
// Purpose  : Load / decrement / zero-flag counter timing the ALARM dwell.
//            A load sets the count to ALARM_CYCLES-1; the dwell ends in the
//            cycle the count reads zero, giving exactly ALARM_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fini_alarm_timer #(
    parameter int ALARM_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    // A single-cycle alarm still needs a 1-bit counter
    localparam int c_TW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_LOAD_VAL = c_TW'(ALARM_CYCLES - 1);

    logic [c_TW-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fini_fault_response.sv
`default_nettype none
// ============================================================================
// Module   : fini_fault_response
// Purpose  : Registered valid/ready stage after FINIandDetection. Forwards
//            fault-free codewords, zeroizes and alarms on flagged words, and
//            locks permanently (until reset) after MAX_FAULTS faults.
// Revision : 1.0 - initial release
// ============================================================================
module fini_fault_response
    import fini_pkg::*;
#(
    parameter int WIDTH        = c_FINI_WIDTH,
    parameter int ALARM_CYCLES = 4,
    parameter int MAX_FAULTS   = 3,
    parameter int CNT_W        = 4
) (
    input  logic             port_clk,
    input  logic             port_rst,
    input  logic [WIDTH-1:0] port_c,
    input  logic             port_errorFlag,
    input  logic             port_inValid,
    output logic             port_inReady,
    output logic [WIDTH-1:0] port_outData,
    output logic             port_outValid,
    input  logic             port_outReady,
    output logic             port_alarm,
    output logic             port_locked,
    output logic [CNT_W-1:0] port_faultCnt
);

    localparam logic [CNT_W-1:0] c_MAX_FAULTS = CNT_W'(MAX_FAULTS);

    fini_state_e      r_state;
    fini_state_e      w_state_next;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_fault_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_fault;
    logic             w_push;
    logic             w_lock;
    logic             w_timer_zero;

    // Ready depends only on registered state and the downstream ready
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || port_outReady);
    assign w_accept   = port_inValid && w_in_ready;
    assign w_fault    = w_accept && port_errorFlag;
    assign w_push     = w_accept && !port_errorFlag;
    assign w_cnt_next = CNT_W'(sat_inc(32'(r_fault_cnt), CNT_W));
    assign w_lock     = (w_cnt_next >= c_MAX_FAULTS);

    // Timer only runs for faults that do not lock the block
    fini_alarm_timer #(
        .ALARM_CYCLES(ALARM_CYCLES)
    ) u_alarm_timer (
        .clk    (port_clk),
        .rst    (port_rst),
        .i_load (w_fault && !w_lock),
        .i_dec  (r_state == ST_ALARM),
        .o_zero (w_timer_zero)
    );

    // State register
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: faults only arrive in RUN, LOCKED is terminal
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_fault) begin
                    w_state_next = w_lock ? ST_LOCKED : ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (w_timer_zero) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_LOCKED: begin
                w_state_next = ST_LOCKED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Output register and fault counter; a fault zeroizes the output word
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_fault_cnt <= '0;
        end else if (r_state == ST_LOCKED) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fault) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_fault_cnt <= w_cnt_next;
        end else if (w_push) begin
            r_out_data  <= port_c;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && port_outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign port_inReady  = w_in_ready;
    assign port_outData  = r_out_data;
    assign port_outValid = r_out_valid;
    assign port_faultCnt = r_fault_cnt;
    assign port_alarm    = (r_state != ST_RUN);
    assign port_locked   = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_fini_fault_response.sv
`default_nettype none
// ============================================================================
// Module   : tb_fini_fault_response
// Purpose  : Self-checking bench for fini_fault_response: vector table for
//            streaming/backpressure/first alarm, hand sequences for lock-up
//            and reset, and a queue scoreboard for forwarded words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fini_fault_response;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] c_in;
    logic       err_flag;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       alarm;
    logic       locked;
    logic [3:0] fault_cnt;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] sb_q[$];

    typedef struct {
        logic       iv;
        logic [3:0] c;
        logic       err;
        logic       ordy;
        logic       rdy;
        logic       ov;
        logic [3:0] od;
        logic       al;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    fini_fault_response #(
        .WIDTH(4), .ALARM_CYCLES(4), .MAX_FAULTS(3), .CNT_W(4)
    ) dut (
        .port_clk       (clk),
        .port_rst       (rst),
        .port_c         (c_in),
        .port_errorFlag (err_flag),
        .port_inValid   (in_valid),
        .port_inReady   (in_ready),
        .port_outData   (out_data),
        .port_outValid  (out_valid),
        .port_outReady  (out_ready),
        .port_alarm     (alarm),
        .port_locked    (locked),
        .port_faultCnt  (fault_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [3:0] od,
                           input logic al, input logic lk, input logic [3:0] cnt);
        chk({tag, " outValid"}, 32'(out_valid), 32'(ov));
        chk({tag, " outData"},  32'(out_data),  32'(od));
        chk({tag, " alarm"},    32'(alarm),     32'(al));
        chk({tag, " locked"},   32'(locked),    32'(lk));
        chk({tag, " faultCnt"}, 32'(fault_cnt), 32'(cnt));
    endtask

    // One clock: drive, check ready before the edge, score pops/pushes, step
    task automatic cyc(input logic iv, input logic [3:0] c, input logic err,
                       input logic ordy, input logic exp_rdy, input string tag);
        logic [3:0] exp_word;
        in_valid  = iv;
        c_in      = c;
        err_flag  = err;
        out_ready = ordy;
        #1;
        chk({tag, " inReady"}, 32'(in_ready), 32'(exp_rdy));
        if (out_valid && ordy) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s pop: actual=word %0h required=no word", tag, out_data);
            end else begin
                exp_word = sb_q.pop_front();
                chk({tag, " popped word"}, 32'(out_data), 32'(exp_word));
            end
        end
        if (iv && exp_rdy && !err) sb_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b1;
        err_flag = 1'b1;
        c_in     = 4'hD;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        err_flag = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        chk_out(tag, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk({tag, " inReady"}, 32'(in_ready), 32'd1);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        //            iv    c     err   ordy | rdy   ov    od    al    cnt
        vecs[0]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'd1};
        vecs[9]  = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'd1};
        vecs[10] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'd1};
        vecs[11] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'd1};
        vecs[12] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd1};
        vecs[13] = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'd1};
        vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 4'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        err_flag  = 1'b0;
        c_in      = 4'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk("reset inReady", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Streaming, backpressure, ignored flag, first alarm and recovery
        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].iv, vecs[i].c, vecs[i].err, vecs[i].ordy, vecs[i].rdy,
                $sformatf("row%0d", i));
            chk_out($sformatf("row%0d", i), vecs[i].ov, vecs[i].od, vecs[i].al,
                    1'b0, vecs[i].cnt);
        end

        // Second fault: dwell must be exactly four cycles, flags during it ignored
        cyc(1'b1, 4'h1, 1'b1, 1'b1, 1'b1, "fault2");
        chk_out("fault2", 1'b0, 4'h0, 1'b1, 1'b0, 4'd2);
        n = 0;
        while (alarm === 1'b1 && n < 20) begin
            cyc(1'b1, 4'hE, 1'b1, 1'b1, 1'b0, "alarm2");
            n++;
        end
        chk("alarm2 dwell", 32'(n), 32'd4);
        chk("alarm2 faultCnt", 32'(fault_cnt), 32'd2);

        // Word pending, then the third fault pops it and locks the block
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 1'b1, "pushB");
        chk_out("pushB", 1'b1, 4'hB, 1'b0, 1'b0, 4'd2);
        cyc(1'b1, 4'hC, 1'b1, 1'b1, 1'b1, "fault3");
        chk_out("fault3", 1'b0, 4'h0, 1'b1, 1'b1, 4'd3);

        // LOCKED holds regardless of inputs
        for (int i = 0; i < 55; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, "locked");
            chk_out("locked", 1'b0, 4'h0, 1'b1, 1'b1, 4'd3);
        end
        chk("scoreboard drained before reset", 32'(sb_q.size()), 32'd0);

        do_reset("rst_locked");

        // Reset in the middle of an alarm
        cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b1, "fault_a");
        chk_out("fault_a", 1'b0, 4'h0, 1'b1, 1'b0, 4'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "mid_alarm");
        chk_out("mid_alarm", 1'b0, 4'h0, 1'b1, 1'b0, 4'd1);
        do_reset("rst_alarm");

        cyc(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, "post_rst");
        chk_out("post_rst", 1'b1, 4'h5, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "post_pop");
        chk_out("post_pop", 1'b0, 4'h5, 1'b0, 1'b0, 4'd0);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
